pla_exhaustive_driver: RTL
==========================

Name: pla_exhaustive_driver

Overview:
- Sequential stimulus/response engine for the 10-input, single-output combinational benchmark netlists (x0..x9 -> y0).
- Drives every input vector 0..2^N_IN-1 onto the DUT inputs and samples y0 after a programmable settle time.
- Also samples a golden expected bit and accumulates a ones count, a CRC-style signature, a mismatch count and the first failing vector.
- Sits in the equivalence/regression harness between the original-PLA and optimised netlists.

Parameters:
N_IN, 10, number of DUT inputs; vector counter width.
SIG_W, 16, signature register width.
POLY, 16'h1021, signature feedback polynomial, truncated or zero-extended to SIG_W.
SEED, 16'hFFFF, signature value loaded at start.
SETTLE_W, 4, width of settle-cycle configuration.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
abort  in  1  stops a running sweep.
settle  in  SETTLE_W  extra wait cycles between applying a vector and sampling it; captured at start.
x  out  N_IN  vector driven to DUT; x[i] connects to DUT input xi.
y0  in  1  DUT response.
exp_y  in  1  golden response for the current x, from the reference model.
busy  out  1  high while the sweep runs.
done  out  1  one-cycle pulse when a sweep completes or is aborted.
aborted  out  1  set with done when the sweep ended by abort; cleared at start.
ones_cnt  out  N_IN+1  number of vectors with y0=1.
sig  out  SIG_W  response signature.
mism_cnt  out  N_IN+1  number of vectors with y0 != exp_y.
first_fail  out  N_IN  lowest failing vector; valid when mism_cnt != 0.

Behaviour:
- Reset (asynchronous, rst_n low) returns every output and register to a fixed value:
  - x=0, busy=0, done=0, aborted=0, ones_cnt=0, mism_cnt=0, first_fail=0.
  - sig=SEED.
  - State=IDLE, wait counter=0, captured settle=0.
- The FSM has three states: IDLE, WAIT, SAMPLE.
- IDLE:
  - On start=1: x<=0, wait<=0, settle captured, ones_cnt<=0, mism_cnt<=0, first_fail<=0, sig<=SEED, aborted<=0, busy<=1.
  - Next state is WAIT if the captured settle is non-zero, else SAMPLE.
- WAIT: wait increments each cycle. When wait==settle-1, go to SAMPLE.
- SAMPLE (one cycle) evaluates y0 and exp_y for the current x:
  - ones_cnt += y0.
  - sig <= {sig[SIG_W-2:0],0} XOR (POLY if sig[SIG_W-1]^y0 else 0).
  - If y0!=exp_y: mism_cnt += 1. If mism_cnt was 0, first_fail<=x.
  - If x==2^N_IN-1: go to IDLE, busy<=0, done<=1 next cycle, x holds its final value.
  - Otherwise: x<=x+1, wait<=0, next state WAIT (settle!=0) or SAMPLE (settle==0).
- Throughput is one vector per settle+1 cycles. The full sweep occupies 2^N_IN*(settle+1) busy cycles.
- done rises in the cycle after the last SAMPLE and is high for exactly one cycle.
- The counters never wrap: the maximum value 2^N_IN fits in N_IN+1 bits.
- Results hold their values in IDLE until the next accepted start.
- abort in WAIT or SAMPLE:
  - Takes priority over that cycle's sample; that vector is not accumulated.
  - Next cycle: state IDLE, busy=0, done=1, aborted=1. Partial results are held.
  - abort in IDLE has no effect.
- start and abort together while IDLE: the start is accepted.
- start while busy is ignored; it causes no restart.
- settle is sampled only at start; changes mid-sweep have no effect.
- Reset asserted mid-sweep forces the reset values immediately. No done pulse is produced.

Test Plan:
- settle=0, y0=0, exp_y=0, SEED overridden to 0 -> busy for 1024 cycles; done exactly 1 cycle after the last sample; ones_cnt=0, mism_cnt=0, sig=0.
- settle=0, y0=1, exp_y=1 -> ones_cnt=1024, mism_cnt=0; x steps 0,1,...,1023, one vector per cycle.
- settle=3, y0 tied to x[0], exp_y=x[0] -> busy for 4096 cycles; each vector held 4 cycles; ones_cnt=512, mism_cnt=0.
- settle=0, y0=x[0], exp_y = x[0] XOR (x==0x2A5 or x==0x3F0) -> mism_cnt=2, first_fail=0x2A5.
- settle=1, abort asserted while x=0x100 -> done=1 and aborted=1 the next cycle; ones_cnt equals the samples taken for vectors below 0x100; start pulses during the sweep are ignored.
- rst_n dropped mid-sweep at x=0x155 -> all outputs return to reset values asynchronously; a subsequent start performs a full clean sweep.

Source files
------------

// File: rtl/pla_exhaustive_driver_if.sv
// Control/result bundle between the exhaustive-sweep engine and its harness.
// The master side is the harness; the slave side is the sweep engine.
interface pla_exhaustive_driver_if #(
    parameter int N_IN     = 10,
    parameter int SIG_W    = 16,
    parameter int SETTLE_W = 4
);
    logic                start;
    logic                abort;
    logic [SETTLE_W-1:0] settle;
    logic [N_IN-1:0]     x;
    logic                y0;
    logic                exp_y;
    logic                busy;
    logic                done;
    logic                aborted;
    logic [N_IN:0]       ones_cnt;
    logic [SIG_W-1:0]    sig;
    logic [N_IN:0]       mism_cnt;
    logic [N_IN-1:0]     first_fail;

    modport master (
        output start, abort, settle, y0, exp_y,
        input  x, busy, done, aborted, ones_cnt, sig, mism_cnt, first_fail
    );

    modport slave (
        input  start, abort, settle, y0, exp_y,
        output x, busy, done, aborted, ones_cnt, sig, mism_cnt, first_fail
    );
endinterface

// File: rtl/pla_exhaustive_driver.sv
// Exhaustive input sweep for an N_IN-input, one-output netlist: drives every
// vector, samples y0 after a settle delay, and accumulates count/signature/compare results.
module pla_exhaustive_driver #(
    parameter int          N_IN     = 10,
    parameter int          SIG_W    = 16,
    parameter logic [15:0] POLY     = 16'h1021,
    parameter logic [15:0] SEED     = 16'hFFFF,
    parameter int          SETTLE_W = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pla_exhaustive_driver_if.slave bus
);
    localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);
    localparam logic [SIG_W-1:0] SEED_W = SIG_W'(SEED);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE} state_t;

    state_t              state;
    logic [SETTLE_W-1:0] wcnt;
    logic [SETTLE_W-1:0] settle_q;
    logic [N_IN-1:0]     x;
    logic                busy;
    logic                done;
    logic                aborted;
    logic [N_IN:0]       ones_cnt;
    logic [N_IN:0]       mism_cnt;
    logic [N_IN-1:0]     first_fail;
    logic [SIG_W-1:0]    sig;

    logic [SIG_W-1:0]    sig_nxt;

    // Shift-left signature with feedback from the outgoing MSB xor the response bit.
    always_comb begin
        sig_nxt = {sig[SIG_W-2:0], 1'b0};
        if (sig[SIG_W-1] ^ bus.y0)
            sig_nxt = sig_nxt ^ POLY_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            settle_q   <= '0;
            x          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            ones_cnt   <= '0;
            mism_cnt   <= '0;
            first_fail <= '0;
            sig        <= SEED_W;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // start wins over a simultaneous abort here
                    if (bus.start) begin
                        x          <= '0;
                        wcnt       <= '0;
                        settle_q   <= bus.settle;
                        ones_cnt   <= '0;
                        mism_cnt   <= '0;
                        first_fail <= '0;
                        sig        <= SEED_W;
                        aborted    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= (bus.settle != '0) ? S_WAIT : S_SAMPLE;
                    end
                end
                S_WAIT: begin
                    if (bus.abort) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        wcnt <= wcnt + SETTLE_W'(1);
                        if (wcnt + SETTLE_W'(1) == settle_q)
                            state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (bus.abort) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        ones_cnt <= ones_cnt + (N_IN+1)'(bus.y0);
                        sig      <= sig_nxt;
                        if (bus.y0 != bus.exp_y) begin
                            mism_cnt <= mism_cnt + (N_IN+1)'(1);
                            if (mism_cnt == '0)
                                first_fail <= x;
                        end
                        if (x == '1) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            x     <= x + N_IN'(1);
                            wcnt  <= '0;
                            state <= (settle_q != '0) ? S_WAIT : S_SAMPLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.x          = x;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.aborted    = aborted;
    assign bus.ones_cnt   = ones_cnt;
    assign bus.mism_cnt   = mism_cnt;
    assign bus.first_fail = first_fail;
    assign bus.sig        = sig;
endmodule
